// File: rtl/mcu_el2_lsu_ecc_wb.sv
// DCCM single-bit ECC write-back queue: holds corrected load data and
// arbitrates for the DCCM write port to scrub the corrected words back.
module mcu_el2_lsu_ecc_wb #(
   parameter int DCCM_BITS  = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ECC_WIDTH  = 7,
   parameter int DEPTH      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dec_tlu_core_ecc_disable,
   input  logic                          enq_valid,
   input  logic                          enq_lo_err,
   input  logic                          enq_hi_err,
   input  logic [DCCM_BITS-1:0]          enq_addr_lo,
   input  logic [DCCM_BITS-1:0]          enq_addr_hi,
   input  logic [DATA_WIDTH-1:0]         enq_data_lo,
   input  logic [DATA_WIDTH-1:0]         enq_data_hi,
   input  logic [ECC_WIDTH-1:0]          enq_ecc_lo,
   input  logic [ECC_WIDTH-1:0]          enq_ecc_hi,
   input  logic                          st_wen,
   input  logic [DCCM_BITS-1:0]          st_addr,
   input  logic                          wb_gnt,
   output logic                          wb_req,
   output logic                          wb_wen_lo,
   output logic                          wb_wen_hi,
   output logic [DCCM_BITS-1:0]          wb_addr_lo,
   output logic [DCCM_BITS-1:0]          wb_addr_hi,
   output logic [DATA_WIDTH+ECC_WIDTH-1:0] wb_wdata_lo,
   output logic [DATA_WIDTH+ECC_WIDTH-1:0] wb_wdata_hi,
   output logic                          wb_full,
   output logic                          wb_overflow,
   output logic [7:0]                    wb_drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = DATA_WIDTH + ECC_WIDTH;

   typedef enum logic [1:0] {IDLE, ARB, WR} state_t;

   state_t                r_state;
   logic [DEPTH-1:0]      r_lo_v;
   logic [DEPTH-1:0]      r_hi_v;
   logic [DCCM_BITS-1:0]  r_addr_lo [DEPTH];
   logic [DCCM_BITS-1:0]  r_addr_hi [DEPTH];
   logic [WW-1:0]         r_wd_lo   [DEPTH];
   logic [WW-1:0]         r_wd_hi   [DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;

   logic                  r_wb_wen_lo, r_wb_wen_hi;
   logic [DCCM_BITS-1:0]  r_wb_addr_lo, r_wb_addr_hi;
   logic [WW-1:0]         r_wb_wdata_lo, r_wb_wdata_hi;
   logic                  r_overflow;
   logic [7:0]            r_drop_cnt;

   logic [DEPTH-1:0]      w_hit_lo, w_hit_hi;
   logic [DEPTH-1:0]      w_lo_live, w_hi_live;
   logic [DEPTH-1:0]      w_lo_nxt, w_hi_nxt;
   logic [AW-1:0]         w_rd_idx, w_wr_idx, w_rd_nxt_idx;
   logic [AW:0]           w_rd_ptr_nxt, w_wr_ptr_nxt;
   logic                  w_empty, w_full;
   logic                  w_head_stored, w_head_live, w_kill;
   logic                  w_req, w_grant, w_pop;
   logic                  w_enq_lo, w_enq_hi, w_enq_try, w_room, w_push, w_drop;
   logic                  w_live_nxt;
   logic                  w_unused;

   assign w_unused = ^st_addr[1:0];

   assign w_rd_idx = r_rd_ptr[AW-1:0];
   assign w_wr_idx = r_wr_ptr[AW-1:0];
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

   // A store to the same word makes the queued correction stale: drop that half.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign w_hit_lo[gi]  = st_wen && (r_addr_lo[gi][DCCM_BITS-1:2] == st_addr[DCCM_BITS-1:2]);
         assign w_hit_hi[gi]  = st_wen && (r_addr_hi[gi][DCCM_BITS-1:2] == st_addr[DCCM_BITS-1:2]);
         assign w_lo_live[gi] = r_lo_v[gi] & ~w_hit_lo[gi];
         assign w_hi_live[gi] = r_hi_v[gi] & ~w_hit_hi[gi];
         assign w_lo_nxt[gi]  = (w_push && (w_wr_idx == AW'(gi))) ? w_enq_lo :
                                (w_pop  && (w_rd_idx == AW'(gi))) ? 1'b0 : w_lo_live[gi];
         assign w_hi_nxt[gi]  = (w_push && (w_wr_idx == AW'(gi))) ? w_enq_hi :
                                (w_pop  && (w_rd_idx == AW'(gi))) ? 1'b0 : w_hi_live[gi];
      end
   endgenerate

   assign w_head_stored = ~w_empty & (r_lo_v[w_rd_idx] | r_hi_v[w_rd_idx]);
   assign w_head_live   = ~w_empty & (w_lo_live[w_rd_idx] | w_hi_live[w_rd_idx]);
   assign w_kill        = (r_state == ARB) & w_head_stored & ~w_head_live;

   assign w_req   = (r_state == ARB) & w_head_live & ~dec_tlu_core_ecc_disable;
   assign w_grant = w_req & wb_gnt;
   // Head leaves either on grant or, with nothing left to write, for free.
   assign w_pop   = ~dec_tlu_core_ecc_disable & ~w_empty & (w_grant | ~w_head_live);

   assign w_enq_lo  = enq_lo_err & ~(st_wen && (enq_addr_lo[DCCM_BITS-1:2] == st_addr[DCCM_BITS-1:2]));
   assign w_enq_hi  = enq_hi_err & ~(st_wen && (enq_addr_hi[DCCM_BITS-1:2] == st_addr[DCCM_BITS-1:2]));
   assign w_enq_try = enq_valid & ~dec_tlu_core_ecc_disable;
   assign w_room    = ~w_full | w_pop;
   assign w_push    = w_enq_try & w_room & (w_enq_lo | w_enq_hi);
   assign w_drop    = w_enq_try & ~w_room;

   assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);
   assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
   assign w_rd_nxt_idx = w_rd_ptr_nxt[AW-1:0];
   assign w_live_nxt   = (w_wr_ptr_nxt != w_rd_ptr_nxt) &
                         (w_lo_nxt[w_rd_nxt_idx] | w_hi_nxt[w_rd_nxt_idx]);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_lo[w_wr_idx] <= enq_addr_lo;
         r_addr_hi[w_wr_idx] <= enq_addr_hi;
         r_wd_lo[w_wr_idx]   <= {enq_ecc_lo, enq_data_lo};
         r_wd_hi[w_wr_idx]   <= {enq_ecc_hi, enq_data_hi};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_lo_v        <= '0;
         r_hi_v        <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_wb_wen_lo   <= 1'b0;
         r_wb_wen_hi   <= 1'b0;
         r_wb_addr_lo  <= '0;
         r_wb_addr_hi  <= '0;
         r_wb_wdata_lo <= '0;
         r_wb_wdata_hi <= '0;
         r_overflow    <= 1'b0;
         r_drop_cnt    <= '0;
      end else begin
         if (dec_tlu_core_ecc_disable) begin
            r_lo_v   <= '0;
            r_hi_v   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            r_lo_v   <= w_lo_nxt;
            r_hi_v   <= w_hi_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
         end

         if (dec_tlu_core_ecc_disable) r_state <= IDLE;
         else if (w_grant)             r_state <= WR;
         else if (w_kill)              r_state <= IDLE;
         else                          r_state <= w_live_nxt ? ARB : IDLE;

         // The granted head is captured here and written during the WR cycle.
         r_wb_wen_lo   <= w_grant & w_lo_live[w_rd_idx];
         r_wb_wen_hi   <= w_grant & w_hi_live[w_rd_idx];
         r_wb_addr_lo  <= (w_grant & w_lo_live[w_rd_idx]) ? r_addr_lo[w_rd_idx] : '0;
         r_wb_addr_hi  <= (w_grant & w_hi_live[w_rd_idx]) ? r_addr_hi[w_rd_idx] : '0;
         r_wb_wdata_lo <= (w_grant & w_lo_live[w_rd_idx]) ? r_wd_lo[w_rd_idx]   : '0;
         r_wb_wdata_hi <= (w_grant & w_hi_live[w_rd_idx]) ? r_wd_hi[w_rd_idx]   : '0;

         r_overflow <= w_drop;
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign wb_req      = w_req;
   assign wb_wen_lo   = r_wb_wen_lo;
   assign wb_wen_hi   = r_wb_wen_hi;
   assign wb_addr_lo  = r_wb_addr_lo;
   assign wb_addr_hi  = r_wb_addr_hi;
   assign wb_wdata_lo = r_wb_wdata_lo;
   assign wb_wdata_hi = r_wb_wdata_hi;
   assign wb_full     = w_full;
   assign wb_overflow = r_overflow;
   assign wb_drop_cnt = r_drop_cnt;

endmodule
